// File: rtl/udp_tick_batch_parser.sv
// rtl/udp_tick_batch_parser.sv - Eth/IPv4/UDP header filter and multi-record tick parser with health counters
module udp_tick_batch_parser #(
    parameter int                      NUM_PORTS = 1,
    parameter logic [NUM_PORTS*16-1:0] PORT_LIST = 16'h04D2,
    parameter logic [15:0]             MAGIC     = 16'hAA55,
    parameter int                      MAX_RECS  = 4,
    parameter int                      CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      eth_axis_tdata,
    input  logic             eth_axis_tvalid,
    input  logic             eth_axis_tlast,
    output logic             eth_axis_tready,
    output logic [31:0]      tick_price,
    output logic [31:0]      tick_qty,
    output logic             tick_is_buy,
    output logic             tick_valid,
    output logic [CNT_W-1:0] cnt_frames_ok,
    output logic [CNT_W-1:0] cnt_frames_drop,
    output logic [CNT_W-1:0] cnt_ticks,
    output logic [CNT_W-1:0] cnt_rec_err
);

    localparam int RC_W = $clog2(MAX_RECS + 1);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_REC_LEN, S_REC_BODY, S_SKIP} state_t;

    state_t            state_q, state_d;
    logic [10:0]       off_q, off_d;
    logic [7:0]        port_hi_q, port_hi_d;
    logic              hdr_pass_q, hdr_pass_d;
    logic [3:0]        rec_idx_q, rec_idx_d;
    logic [RC_W-1:0]   rec_cnt_q, rec_cnt_d;
    logic [31:0]       price_q, price_d;
    logic [31:0]       qty_q, qty_d;
    logic [7:0]        side_q, side_d;
    logic [7:0]        xor_q, xor_d;

    logic              fire_d;
    logic [31:0]       fire_price_d;
    logic [31:0]       fire_qty_d;
    logic              fire_buy_d;
    logic [1:0]        err_inc_d;
    logic [11:0]       pos;
    logic [7:0]        byte_v;

    logic [31:0]       tick_price_q, tick_qty_q;
    logic              tick_is_buy_q, tick_valid_q;
    logic [CNT_W-1:0]  cnt_ok_q, cnt_drop_q, cnt_ticks_q, cnt_err_q;

    function automatic logic port_match(input logic [15:0] port);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (PORT_LIST[16*i +: 16] == port) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, c} + (CNT_W+1)'(inc);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // Walk the four lanes of the current beat in byte order, carrying parse state lane to lane
    always_comb begin
        state_d      = state_q;
        port_hi_d    = port_hi_q;
        hdr_pass_d   = hdr_pass_q;
        rec_idx_d    = rec_idx_q;
        rec_cnt_d    = rec_cnt_q;
        price_d      = price_q;
        qty_d        = qty_q;
        side_d       = side_q;
        xor_d        = xor_q;
        fire_d       = 1'b0;
        fire_price_d = price_q;
        fire_qty_d   = qty_q;
        fire_buy_d   = 1'b0;
        err_inc_d    = 2'd0;
        pos          = 12'd0;
        byte_v       = 8'd0;
        off_d        = (off_q >= 11'd2044) ? 11'd2047 : off_q + 11'd4;

        if (state_d == S_IDLE) begin
            state_d    = S_HDR;
            hdr_pass_d = 1'b0;
            rec_cnt_d  = '0;
        end

        for (int lane = 0; lane < 4; lane++) begin
            pos    = {1'b0, off_q} + 12'(lane);
            byte_v = eth_axis_tdata[8*lane +: 8];
            // Once the offset has saturated nothing further in the frame is interpreted
            if (pos < 12'd2047) begin
                case (state_d)
                    S_HDR: begin
                        case (pos)
                            12'd12: if (byte_v != 8'h08) state_d = S_SKIP;
                            12'd13: if (byte_v != 8'h00) state_d = S_SKIP;
                            12'd23: if (byte_v != 8'h11) state_d = S_SKIP;
                            12'd36: port_hi_d = byte_v;
                            12'd37: if (!port_match({port_hi_d, byte_v})) state_d = S_SKIP;
                            12'd42: if (byte_v != MAGIC[15:8]) state_d = S_SKIP;
                            12'd43: begin
                                if (byte_v != MAGIC[7:0]) begin
                                    state_d = S_SKIP;
                                end else begin
                                    state_d    = S_REC_LEN;
                                    hdr_pass_d = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    S_REC_LEN: begin
                        if (byte_v == 8'h09) begin
                            state_d   = S_REC_BODY;
                            rec_idx_d = 4'd0;
                            xor_d     = 8'h00;
                        end else begin
                            // A zero length byte is trailing padding, anything else is corruption
                            state_d = S_SKIP;
                            if (byte_v != 8'h00) err_inc_d = err_inc_d + 2'd1;
                        end
                    end
                    S_REC_BODY: begin
                        if (rec_idx_d < 4'd4)       price_d = {price_d[23:0], byte_v};
                        else if (rec_idx_d < 4'd8)  qty_d   = {qty_d[23:0], byte_v};
                        else if (rec_idx_d == 4'd8) side_d  = byte_v;

                        if (rec_idx_d == 4'd9) begin
                            rec_cnt_d = rec_cnt_d + RC_W'(1);
                            if (xor_d == byte_v && (side_d == 8'h42 || side_d == 8'h53)) begin
                                // Snapshot here: later lanes may already start the next record
                                fire_d       = 1'b1;
                                fire_price_d = price_d;
                                fire_qty_d   = qty_d;
                                fire_buy_d   = (side_d == 8'h42);
                            end else begin
                                err_inc_d = err_inc_d + 2'd1;
                            end
                            state_d = (rec_cnt_d == RC_W'(MAX_RECS)) ? S_SKIP : S_REC_LEN;
                        end else begin
                            xor_d     = xor_d ^ byte_v;
                            rec_idx_d = rec_idx_d + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Commit parse state, tick outputs and health counters on each accepted beat
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            off_q         <= '0;
            port_hi_q     <= '0;
            hdr_pass_q    <= 1'b0;
            rec_idx_q     <= '0;
            rec_cnt_q     <= '0;
            price_q       <= '0;
            qty_q         <= '0;
            side_q        <= '0;
            xor_q         <= '0;
            tick_price_q  <= '0;
            tick_qty_q    <= '0;
            tick_is_buy_q <= 1'b0;
            tick_valid_q  <= 1'b0;
            cnt_ok_q      <= '0;
            cnt_drop_q    <= '0;
            cnt_ticks_q   <= '0;
            cnt_err_q     <= '0;
        end else begin
            tick_valid_q <= 1'b0;
            if (eth_axis_tvalid) begin
                if (fire_d) begin
                    tick_price_q  <= fire_price_d;
                    tick_qty_q    <= fire_qty_d;
                    tick_is_buy_q <= fire_buy_d;
                    tick_valid_q  <= 1'b1;
                    cnt_ticks_q   <= sat_add(cnt_ticks_q, 2'd1);
                end
                cnt_err_q <= sat_add(cnt_err_q, err_inc_d);
                port_hi_q <= port_hi_d;
                rec_idx_q <= rec_idx_d;
                price_q   <= price_d;
                qty_q     <= qty_d;
                side_q    <= side_d;
                xor_q     <= xor_d;
                if (eth_axis_tlast) begin
                    state_q    <= S_IDLE;
                    off_q      <= '0;
                    hdr_pass_q <= 1'b0;
                    rec_cnt_q  <= '0;
                    if (hdr_pass_d) cnt_ok_q   <= sat_add(cnt_ok_q, 2'd1);
                    else            cnt_drop_q <= sat_add(cnt_drop_q, 2'd1);
                end else begin
                    state_q    <= state_d;
                    off_q      <= off_d;
                    hdr_pass_q <= hdr_pass_d;
                    rec_cnt_q  <= rec_cnt_d;
                end
            end
        end
    end

    assign eth_axis_tready = ~rst;
    assign tick_price      = tick_price_q;
    assign tick_qty        = tick_qty_q;
    assign tick_is_buy     = tick_is_buy_q;
    assign tick_valid      = tick_valid_q;
    assign cnt_frames_ok   = cnt_ok_q;
    assign cnt_frames_drop = cnt_drop_q;
    assign cnt_ticks       = cnt_ticks_q;
    assign cnt_rec_err     = cnt_err_q;

endmodule

// File: tb/tb_udp_tick_batch_parser.sv
// tb/tb_udp_tick_batch_parser.sv - scoreboard bench for udp_tick_batch_parser (single- and dual-port builds)
module tb_udp_tick_batch_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tdata;
    logic        tvalid, tlast;

    logic        tready_a, tick_valid_a, tick_is_buy_a;
    logic [31:0] tick_price_a, tick_qty_a;
    logic [15:0] ok_a, drop_a, ticks_a, err_a;
    logic        tready_b, tick_valid_b, tick_is_buy_b;
    logic [31:0] tick_price_b, tick_qty_b;
    logic [15:0] ok_b, drop_b, ticks_b, err_b;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ok, exp_drop, exp_ticks, exp_err, exp_ok_b;

    logic [64:0] exp_a[$];
    logic [64:0] exp_b[$];
    logic [64:0] e_a, e_b;
    logic [7:0]  frm[$];

    always #4 clk = ~clk;

    udp_tick_batch_parser #(.NUM_PORTS(1), .PORT_LIST(16'h04D2)) dut_a (
        .clk(clk), .rst(rst),
        .eth_axis_tdata(tdata), .eth_axis_tvalid(tvalid), .eth_axis_tlast(tlast), .eth_axis_tready(tready_a),
        .tick_price(tick_price_a), .tick_qty(tick_qty_a), .tick_is_buy(tick_is_buy_a), .tick_valid(tick_valid_a),
        .cnt_frames_ok(ok_a), .cnt_frames_drop(drop_a), .cnt_ticks(ticks_a), .cnt_rec_err(err_a)
    );

    udp_tick_batch_parser #(.NUM_PORTS(2), .PORT_LIST({16'h04D3, 16'h04D2})) dut_b (
        .clk(clk), .rst(rst),
        .eth_axis_tdata(tdata), .eth_axis_tvalid(tvalid), .eth_axis_tlast(tlast), .eth_axis_tready(tready_b),
        .tick_price(tick_price_b), .tick_qty(tick_qty_b), .tick_is_buy(tick_is_buy_b), .tick_valid(tick_valid_b),
        .cnt_frames_ok(ok_b), .cnt_frames_drop(drop_b), .cnt_ticks(ticks_b), .cnt_rec_err(err_b)
    );

    // Scoreboard: every tick pulse must match the oldest outstanding expected record
    always @(negedge clk) begin
        if (tick_valid_a) begin
            n_checks++;
            if (exp_a.size() == 0) begin
                n_fail++;
                $display("FAIL tick_a_unexpected: got price=%0d qty=%0d buy=%0d, required no pulse", tick_price_a, tick_qty_a, tick_is_buy_a);
            end else begin
                e_a = exp_a.pop_front();
                if ({tick_price_a, tick_qty_a, tick_is_buy_a} !== e_a) begin
                    n_fail++;
                    $display("FAIL tick_a_fields: got price=%0d qty=%0d buy=%0d, required price=%0d qty=%0d buy=%0d",
                             tick_price_a, tick_qty_a, tick_is_buy_a, e_a[64:33], e_a[32:1], e_a[0]);
                end
            end
        end
        if (tick_valid_b) begin
            n_checks++;
            if (exp_b.size() == 0) begin
                n_fail++;
                $display("FAIL tick_b_unexpected: got price=%0d qty=%0d buy=%0d, required no pulse", tick_price_b, tick_qty_b, tick_is_buy_b);
            end else begin
                e_b = exp_b.pop_front();
                if ({tick_price_b, tick_qty_b, tick_is_buy_b} !== e_b) begin
                    n_fail++;
                    $display("FAIL tick_b_fields: got price=%0d qty=%0d buy=%0d, required price=%0d qty=%0d buy=%0d",
                             tick_price_b, tick_qty_b, tick_is_buy_b, e_b[64:33], e_b[32:1], e_b[0]);
                end
            end
        end
    end

    task automatic new_frame(input logic [15:0] port);
        frm.delete();
        for (int i = 0; i < 44; i++) frm.push_back(8'(i * 7 + 1));
        frm[12] = 8'h08; frm[13] = 8'h00; frm[23] = 8'h11;
        frm[36] = port[15:8]; frm[37] = port[7:0];
        frm[42] = 8'hAA; frm[43] = 8'h55;
    endtask

    task automatic add_rec(input logic [31:0] p, input logic [31:0] q, input logic [7:0] side, input logic corrupt);
        logic [7:0] x;
        x = p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0] ^ q[31:24] ^ q[23:16] ^ q[15:8] ^ q[7:0] ^ side;
        if (corrupt) x = x ^ 8'h5A;
        frm.push_back(8'h09);
        for (int i = 3; i >= 0; i--) frm.push_back(p[8*i +: 8]);
        for (int i = 3; i >= 0; i--) frm.push_back(q[8*i +: 8]);
        frm.push_back(side);
        frm.push_back(x);
    endtask

    // Sends the frame in 4-byte beats; cut>0 truncates, gap_beat>=0 inserts 3 idle cycles before that beat
    task automatic send_frame(input int cut, input int gap_beat, input logic with_last);
        int nb;
        while (frm.size() % 4 != 0) frm.push_back(8'h00);
        nb = frm.size() / 4;
        if (cut > 0 && cut < nb) nb = cut;
        for (int b = 0; b < nb; b++) begin
            if (b == gap_beat) begin
                for (int g = 0; g < 3; g++) begin
                    tdata = $urandom;
                    tlast = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                tlast = 1'b0;
            end
            tdata  = {frm[4*b+3], frm[4*b+2], frm[4*b+1], frm[4*b]};
            tvalid = 1'b1;
            tlast  = with_last && (b == nb - 1);
            @(posedge clk); #1;
            tvalid = 1'b0;
            tlast  = 1'b0;
        end
    endtask

    task automatic push_both(input logic [31:0] p, input logic [31:0] q, input logic buy);
        exp_a.push_back({p, q, buy});
        exp_b.push_back({p, q, buy});
    endtask

    task automatic settle_and_check(input string name);
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing_ticks: got %0d/%0d records still outstanding, required 0/0", name, exp_a.size(), exp_b.size());
            exp_a.delete();
            exp_b.delete();
        end
        n_checks++;
        if ({ok_a, drop_a, ticks_a, err_a} !== {16'(exp_ok), 16'(exp_drop), 16'(exp_ticks), 16'(exp_err)}) begin
            n_fail++;
            $display("FAIL %s_counters: got ok=%0d drop=%0d ticks=%0d err=%0d, required ok=%0d drop=%0d ticks=%0d err=%0d",
                     name, ok_a, drop_a, ticks_a, err_a, exp_ok, exp_drop, exp_ticks, exp_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (tready_a !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %0b, required 0", tready_a); end
        n_checks++;
        if ({tick_valid_a, tick_price_a, tick_qty_a, tick_is_buy_a} !== 66'd0) begin
            n_fail++; $display("FAIL reset_tick_outputs: got valid=%0b price=%0d qty=%0d buy=%0b, required all 0", tick_valid_a, tick_price_a, tick_qty_a, tick_is_buy_a);
        end
        n_checks++;
        if ({ok_a, drop_a, ticks_a, err_a} !== 64'd0) begin
            n_fail++; $display("FAIL reset_counters: got ok=%0d drop=%0d ticks=%0d err=%0d, required all 0", ok_a, drop_a, ticks_a, err_a);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (tready_a !== 1'b1) begin n_fail++; $display("FAIL reset_tready_release: got %0b, required 1", tready_a); end
        @(posedge clk); #1;
        exp_ok = 0; exp_drop = 0; exp_ticks = 0; exp_err = 0; exp_ok_b = 0;
    endtask

    task automatic test_single();
        new_frame(16'h04D2);
        add_rec(32'd100, 32'd50, 8'h42, 1'b0);
        push_both(32'd100, 32'd50, 1'b1);
        send_frame(0, -1, 1'b1);
        exp_ok++; exp_ticks++; exp_ok_b++;
        settle_and_check("single");
        n_checks++;
        if ({tick_price_a, tick_qty_a, tick_is_buy_a} !== {32'd100, 32'd50, 1'b1}) begin
            n_fail++; $display("FAIL single_hold: got price=%0d qty=%0d buy=%0b, required 100/50/1", tick_price_a, tick_qty_a, tick_is_buy_a);
        end
    endtask

    task automatic test_multi();
        new_frame(16'h04D2);
        add_rec(32'd105, 32'd75, 8'h42, 1'b0);
        add_rec(32'd110, 32'd25, 8'h53, 1'b0);
        add_rec(32'd108, 32'd30, 8'h53, 1'b0);
        frm.push_back(8'h00);
        push_both(32'd105, 32'd75, 1'b1);
        push_both(32'd110, 32'd25, 1'b0);
        push_both(32'd108, 32'd30, 1'b0);
        send_frame(0, -1, 1'b1);
        exp_ok++; exp_ticks += 3; exp_ok_b++;
        settle_and_check("multi");
    endtask

    task automatic test_port_whitelist();
        new_frame(16'h04D3);
        add_rec(32'd120, 32'd5, 8'h42, 1'b0);
        exp_b.push_back({32'd120, 32'd5, 1'b1});
        send_frame(0, -1, 1'b1);
        exp_drop++; exp_ok_b++;
        settle_and_check("port");
        n_checks++;
        if (ok_b !== 16'(exp_ok_b)) begin
            n_fail++; $display("FAIL port_two_port_ok: got %0d, required %0d", ok_b, exp_ok_b);
        end
    endtask

    task automatic test_bad_xor();
        new_frame(16'h04D2);
        add_rec(32'd77, 32'd7, 8'h42, 1'b1);
        add_rec(32'h01020304, 32'hA0B0C0D0, 8'h53, 1'b0);
        push_both(32'h01020304, 32'hA0B0C0D0, 1'b0);
        send_frame(0, -1, 1'b1);
        exp_ok++; exp_ticks++; exp_err++; exp_ok_b++;
        settle_and_check("bad_xor");
    endtask

    task automatic test_valid_gap();
        new_frame(16'h04D2);
        add_rec(32'd100, 32'd50, 8'h42, 1'b0);
        push_both(32'd100, 32'd50, 1'b1);
        send_frame(0, 12, 1'b1);
        exp_ok++; exp_ticks++; exp_ok_b++;
        settle_and_check("gap");
    endtask

    task automatic test_runt();
        new_frame(16'h04D2);
        add_rec(32'd100, 32'd50, 8'h42, 1'b0);
        send_frame(6, -1, 1'b1);
        exp_drop++;
        settle_and_check("runt");
    endtask

    task automatic test_max_recs();
        new_frame(16'h04D2);
        for (int i = 0; i < 6; i++) begin
            add_rec(32'(1000 + i), 32'(10 + i), (i % 2 == 0) ? 8'h42 : 8'h53, 1'b0);
            if (i < 4) push_both(32'(1000 + i), 32'(10 + i), (i % 2 == 0));
        end
        send_frame(0, -1, 1'b1);
        exp_ok++; exp_ticks += 4; exp_ok_b++;
        settle_and_check("max_recs");
    endtask

    task automatic test_back_to_back();
        new_frame(16'h04D2);
        add_rec(32'd200, 32'd10, 8'h53, 1'b0);
        push_both(32'd200, 32'd10, 1'b0);
        send_frame(0, -1, 1'b1);
        new_frame(16'h04D2);
        add_rec(32'd300, 32'd20, 8'h42, 1'b0);
        push_both(32'd300, 32'd20, 1'b1);
        send_frame(0, -1, 1'b1);
        exp_ok += 2; exp_ticks += 2; exp_ok_b += 2;
        settle_and_check("back_to_back");
    endtask

    task automatic test_reset_mid_frame();
        new_frame(16'h04D2);
        add_rec(32'd999, 32'd9, 8'h42, 1'b0);
        send_frame(12, -1, 1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({tready_a, ok_a, drop_a, ticks_a, err_a} !== 65'd0) begin
            n_fail++; $display("FAIL midrst_cleared: got tready=%0b ok=%0d drop=%0d ticks=%0d, required all 0", tready_a, ok_a, drop_a, ticks_a);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        exp_ok = 0; exp_drop = 0; exp_ticks = 0; exp_err = 0; exp_ok_b = 0;
        new_frame(16'h04D2);
        add_rec(32'd100, 32'd50, 8'h42, 1'b0);
        push_both(32'd100, 32'd50, 1'b1);
        send_frame(0, -1, 1'b1);
        exp_ok++; exp_ticks++; exp_ok_b++;
        settle_and_check("midrst");
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_port_whitelist();
        test_bad_xor();
        test_valid_gap();
        test_runt();
        test_max_recs();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
